// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: queues register-to-register moves and runs each as DRIVE then LOAD on the shared bus.
// Optional readback verify of the destination is enabled by defining READBACK_CHECK_EN.
module bus_transfer_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int SEL_W = 5,
    parameter int MAX_SEL = 22,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_src,
    input  logic [SEL_W-1:0] req_dst,
    output logic [SEL_W-1:0] reg_out_select,
    output logic             bus_drive,
    output logic [SEL_W-1:0] load_sel,
    output logic             load,
    output logic             done,
    output logic             req_err,
    output logic [CW-1:0]    queue_count,
`ifdef READBACK_CHECK_EN
    input  logic [31:0]      bus_in,
    output logic             chk_err,
`endif
    output logic             busy
);
    localparam logic [SEL_W-1:0] MAX_C = SEL_W'(MAX_SEL);
`ifdef READBACK_CHECK_EN
    typedef enum logic [2:0] {IDLE, DRIVE, LOAD, VERIFY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DRIVE, LOAD, DONE} state_t;
`endif
    state_t           state_q, state_d;
    logic [SEL_W-1:0] src_mem_q [FIFO_DEPTH];
    logic [SEL_W-1:0] dst_mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic [SEL_W-1:0] cur_src_q, cur_dst_q;
    logic             err_q, legal, push, pop;
`ifdef READBACK_CHECK_EN
    logic [31:0]      data_q;
    logic             mis_q;
`endif
    assign legal       = req_src <= MAX_C && req_dst <= MAX_C;
    assign req_ready   = cnt_q != CW'(FIFO_DEPTH);
    assign push        = req_valid && req_ready && legal;
    assign pop         = state_q == IDLE && cnt_q != '0;
    assign req_err     = err_q;
    assign queue_count = cnt_q;
    assign busy        = state_q != IDLE || cnt_q != '0;
    // Queue storage, pointers, current move and FSM state; reset abandons any move in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            err_q     <= 1'b0;
`ifdef READBACK_CHECK_EN
            data_q    <= '0;
            mis_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            err_q   <= req_valid && req_ready && !legal;
            if (push) begin
                src_mem_q[wr_q] <= req_src;
                dst_mem_q[wr_q] <= req_dst;
                wr_q            <= wr_q + 1'b1;
            end
            if (pop) begin
                cur_src_q <= src_mem_q[rd_q];
                cur_dst_q <= dst_mem_q[rd_q];
                rd_q      <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
`ifdef READBACK_CHECK_EN
            if (state_q == LOAD) data_q <= bus_in;
            if (state_q == VERIFY) mis_q <= data_q != bus_in;
`endif
        end
    end
    // Next state and bus/load controls decoded from the current state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pop ? DRIVE : IDLE;
            DRIVE:   state_d = LOAD;
`ifdef READBACK_CHECK_EN
            LOAD:    state_d = VERIFY;
            VERIFY:  state_d = DONE;
`else
            LOAD:    state_d = DONE;
`endif
            default: state_d = IDLE;
        endcase
        bus_drive      = state_q == DRIVE || state_q == LOAD;
        reg_out_select = bus_drive ? cur_src_q : '0;
        load           = state_q == LOAD;
        load_sel       = load ? cur_dst_q : '0;
        done           = state_q == DONE;
`ifdef READBACK_CHECK_EN
        bus_drive      = bus_drive || state_q == VERIFY;
        reg_out_select = state_q == VERIFY ? cur_dst_q : reg_out_select;
        chk_err        = done && mis_q;
`endif
    end
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// tb_bus_transfer_sequencer: directed bench for bus_transfer_sequencer (READBACK_CHECK_EN-aware).
module tb_bus_transfer_sequencer;
`ifdef READBACK_CHECK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b0, req_valid = 1'b0;
    logic [4:0]  req_src = '0, req_dst = '0;
    logic        req_ready, bus_drive, load, done, req_err, busy;
    logic [4:0]  reg_out_select, load_sel;
    logic [2:0]  queue_count;
`ifdef READBACK_CHECK_EN
    logic [31:0] bus_in = '0;
    logic        chk_err;
`endif
    int          n_chk = 0, n_err = 0, cyc = 0, fs = 0;
    logic [9:0]  ld_q[$], exp_q[$];
    int          done_q[$];

    bus_transfer_sequencer dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .reg_out_select(reg_out_select),
        .bus_drive(bus_drive), .load_sel(load_sel), .load(load), .done(done),
        .req_err(req_err), .queue_count(queue_count),
`ifdef READBACK_CHECK_EN
        .bus_in(bus_in), .chk_err(chk_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (load) ld_q.push_back({reg_out_select, load_sel});
        if (done) done_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        for (int i = 0; i < 200 && busy; i++) tick();
        check("drain_idle", 32'(busy), 0);
    endtask

    task automatic cmp_order(input string tag);
        check({tag, "_nload"}, 32'(ld_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < ld_q.size(); i++) check(tag, 32'(ld_q[i]), 32'(exp_q[i]));
        ld_q.delete();
        exp_q.delete();
        done_q.delete();
    endtask

    task automatic burst(input int n, input int base, output int full_seen);
        full_seen = 0;
        for (int i = 0; i < n; i++) begin
            req_src   = 5'((base + i) % 23);
            req_dst   = 5'((base + 3 * i + 1) % 23);
            req_valid = 1'b1;
            for (int w = 0; w < 50 && !req_ready; w++) begin
                if (full_seen == 0) check("full_count", 32'(queue_count), 4);
                full_seen = 1;
                tick();
            end
            exp_q.push_back({req_src, req_dst});
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic single(input logic [4:0] s, input logic [4:0] d, input bit mism);
`ifdef READBACK_CHECK_EN
        bus_in = 32'hA5;
`endif
        req_src = s;
        req_dst = d;
        req_valid = 1'b1;
        exp_q.push_back({s, d});
        tick();
        req_valid = 1'b0;
        check("n1_count", 32'(queue_count), 1);
        check("n1_drive", 32'(bus_drive), 0);
        tick();
        check("n2_drive", 32'(bus_drive), 1);
        check("n2_sel", 32'(reg_out_select), 32'(s));
        check("n2_load", 32'(load), 0);
        check("n2_count", 32'(queue_count), 0);
        tick();
        check("n3_load", 32'(load), 1);
        check("n3_load_sel", 32'(load_sel), 32'(d));
        check("n3_sel", 32'(reg_out_select), 32'(s));
`ifdef READBACK_CHECK_EN
        tick();
        check("v_sel", 32'(reg_out_select), 32'(d));
        check("v_drive", 32'(bus_drive), 1);
        check("v_load", 32'(load), 0);
        if (mism) bus_in = 32'h5A;
`endif
        tick();
        check("n4_done", 32'(done), 1);
        check("n4_drive", 32'(bus_drive), 0);
        check("n4_load", 32'(load), 0);
`ifdef READBACK_CHECK_EN
        check("n4_chk_err", 32'(chk_err), 32'(mism));
`endif
        tick();
        check("idle_done", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_sel", 32'(reg_out_select), 0);
        check("idle_load_sel", 32'(load_sel), 0);
        cmp_order(RB ? "single_rb" : "single");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 1);
        check("rst_count", 32'(queue_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_drive", 32'(bus_drive), 0);
        check("rst_load", 32'(load), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sel", 32'(reg_out_select), 0);
        reset = 1'b1;
        tick();

        single(5'd3, 5'd7, 1'b0);
        single(5'd4, 5'd5, 1'b1);

        req_src = 5'd25;
        req_dst = 5'd2;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("ill_err", 32'(req_err), 1);
        check("ill_count", 32'(queue_count), 0);
        check("ill_busy", 32'(busy), 0);
        tick();
        check("ill_err_clr", 32'(req_err), 0);
        req_src = 5'd1;
        req_dst = 5'd20;
        req_valid = 1'b1;
        exp_q.push_back({5'd1, 5'd20});
        tick();
        req_valid = 1'b0;
        check("legal_err", 32'(req_err), 0);
        drain();
        check("ill_ndone", 32'(done_q.size()), 1);
        cmp_order("illegal");

        burst(6, 8, fs);
        check("burst_full_seen", 32'(fs), 1);
        drain();
        check("burst_ndone", 32'(done_q.size()), 6);
        for (int i = 1; i < done_q.size(); i++) check("burst_spacing", 32'(done_q[i] - done_q[i-1]), 4);
        cmp_order("burst");

        req_valid = 1'b1;
        req_src = 5'd10; req_dst = 5'd11; tick();
        req_src = 5'd12; req_dst = 5'd13; tick();
        req_src = 5'd14; req_dst = 5'd15; tick();
        req_valid = 1'b0;
        check("rstmid_load", 32'(load), 1);
        check("rstmid_count", 32'(queue_count), 2);
        reset = 1'b0;
        tick();
        check("rstmid_count0", 32'(queue_count), 0);
        check("rstmid_load0", 32'(load), 0);
        check("rstmid_done0", 32'(done), 0);
        check("rstmid_ready", 32'(req_ready), 1);
        reset = 1'b1;
        repeat (6) tick();
        check("rstmid_ready_rel", 32'(req_ready), 1);
        check("rstmid_nload", 32'(ld_q.size()), 1);
        check("rstmid_ndone", 32'(done_q.size()), 0);
        ld_q.delete();
        done_q.delete();

        req_valid = 1'b1;
        req_src = 5'd0;  req_dst = 5'd22; exp_q.push_back({req_src, req_dst}); tick();
        req_src = 5'd21; req_dst = 5'd16; exp_q.push_back({req_src, req_dst}); tick();
        req_src = 5'd17; req_dst = 5'd17; exp_q.push_back({req_src, req_dst}); tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("pp_count_before", 32'(queue_count), 2);
        check("pp_idle", 32'(bus_drive), 0);
        req_src = 5'd18; req_dst = 5'd19; req_valid = 1'b1; exp_q.push_back({req_src, req_dst});
        tick();
        req_valid = 1'b0;
        check("pp_count_after", 32'(queue_count), 2);
        check("pp_drive", 32'(bus_drive), 1);
        burst(10, 5, fs);
        drain();
        check("wrap_ndone", 32'(done_q.size()), 14);
        cmp_order("wrap");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
